lcd_refresher: RTL and testbench

Display-side reader for the 2x16 history RAM. Continuously scans all 32 character cells and copies them to an HD44780-compatible character LCD over its 8-bit parallel bus. Runs the LCD power-on initialisation first, then refreshes frames forever, so every RAM write lands on the glass within one frame time. Sits between the dual-port history RAM read port and the LCD pins.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_byte_writer.sv | 106 ++++++++++
 rtl/lcd_refresher.sv | 159 +++++++++++++++
 tb/tb_lcd_refresher.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Purpose : shared state encodings, HD44780 command bytes and delay-counter width
//           for the LCD refresher and its byte writer.
// Contents: state_e (sequencer), phase_e (byte writer), command constants, init_cmd().
package lcd_pkg;

    localparam int DLY_W = 20;

    localparam logic [7:0] FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, cursor off, blink off
    localparam logic [7:0] ENTRY_MODE = 8'h06;  // increment address, no shift
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] ROW0_ADDR  = 8'h80;  // set DDRAM address 0x00
    localparam logic [7:0] ROW1_ADDR  = 8'hC0;  // set DDRAM address 0x40

    typedef enum logic [2:0] {
        ST_POWER_WAIT,
        ST_INIT,
        ST_SET_ROW,
        ST_FETCH,
        ST_WRITE_CHAR,
        ST_FRAME_END
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHI,
        PH_SETTLE
    } phase_e;

    // Power-on command sequence, in issue order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY_MODE;
            default: return CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Purpose : writes one byte to the LCD bus: 1 setup clock, E_CYC clocks of E high,
//           then CMD_CYC (or CLEAR_CYC when long_settle_i) settle clocks.
// Latency : 1 + E_CYC + settle clocks per byte; a new start is accepted in the last
//           settle clock so consecutive bytes run back to back.
// Backpressure: busy_o high means start_i is ignored this clock.
// Ports   : clk_i, rst_ni, start_i/rs_i/byte_i/long_settle_i in; busy_o, lcd_e_o,
//           lcd_rs_o, lcd_data_o out.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int E_CYC     = 25,
    parameter int CMD_CYC   = 2000,
    parameter int CLEAR_CYC = 82000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] byte_i,
    input  logic       long_settle_i,
    output logic       busy_o,
    output logic       lcd_e_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_data_o
);

    localparam logic [DLY_W-1:0] E_LD   = DLY_W'(E_CYC - 1);
    localparam logic [DLY_W-1:0] CMD_LD = DLY_W'(CMD_CYC - 1);
    localparam logic [DLY_W-1:0] CLR_LD = DLY_W'(CLEAR_CYC - 1);
    localparam logic [DLY_W-1:0] ONE    = DLY_W'(1);

    phase_e           phase_q, phase_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             long_q, long_d;
    logic             lcd_e_q;
    logic             accept;

    // Free in idle or during the final settle clock, so the next setup clock
    // directly follows the current settle window.
    assign busy_o = !((phase_q == PH_IDLE) ||
                      ((phase_q == PH_SETTLE) && (cnt_q == '0)));
    assign accept = start_i && !busy_o;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        long_d  = long_q;
        case (phase_q)
            PH_SETUP: begin
                phase_d = PH_EHI;
                cnt_d   = E_LD;
            end
            PH_EHI: begin
                if (cnt_q == '0) begin
                    phase_d = PH_SETTLE;
                    cnt_d   = long_q ? CLR_LD : CMD_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            PH_SETTLE: begin
                if (cnt_q == '0) begin
                    phase_d = PH_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: ;
        endcase
        // rs/data only change here, at the start of setup, so they stay put
        // throughout the E pulse and the settle window.
        if (accept) begin
            phase_d = PH_SETUP;
            rs_d    = rs_i;
            data_d  = byte_i;
            long_d  = long_settle_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
            lcd_e_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
            lcd_e_q <= (phase_d == PH_EHI);
        end
    end

    assign lcd_e_o    = lcd_e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_refresher.sv
// Purpose : power-on init of an HD44780 LCD, then endless copy of the 2x16 history
//           RAM to the glass, row-address command before each row.
// Latency : one frame = 34 byte writes + 32 fetch clocks + 1 frame-end clock.
// Backpressure: none upstream; the RAM read port is always ready, pacing comes
//           from the byte writer's busy.
// Ports   : clk_i, rst_ni, rdata_i in; raddr_o, lcd_rs_o, lcd_rw_o, lcd_e_o,
//           lcd_data_o, ready_o, frame_done_o out.
module lcd_refresher
    import lcd_pkg::*;
#(
    parameter int POWER_CYC = 750000,
    parameter int E_CYC     = 25,
    parameter int CMD_CYC   = 2000,
    parameter int CLEAR_CYC = 82000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [4:0] raddr_o,
    input  logic [7:0] rdata_i,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o,
    output logic       ready_o,
    output logic       frame_done_o
);

    localparam logic [DLY_W-1:0] PWR_LAST = DLY_W'(POWER_CYC - 1);
    localparam logic [DLY_W-1:0] ONE      = DLY_W'(1);

    state_e           state_q, state_d;
    logic [4:0]       raddr_q, raddr_d;
    logic             ready_q, ready_d;
    logic             frame_done_q, frame_done_d;
    logic [DLY_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [2:0]       init_idx_q, init_idx_d;

    logic             wr_start;
    logic             wr_rs;
    logic [7:0]       wr_byte;
    logic             wr_long;
    logic             wr_busy;

    lcd_byte_writer #(
        .E_CYC     (E_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLEAR_CYC (CLEAR_CYC)
    ) u_writer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (wr_start),
        .rs_i          (wr_rs),
        .byte_i        (wr_byte),
        .long_settle_i (wr_long),
        .busy_o        (wr_busy),
        .lcd_e_o       (lcd_e_o),
        .lcd_rs_o      (lcd_rs_o),
        .lcd_data_o    (lcd_data_o)
    );

    always_comb begin
        state_d      = state_q;
        raddr_d      = raddr_q;
        ready_d      = ready_q;
        frame_done_d = 1'b0;
        pwr_cnt_d    = pwr_cnt_q;
        init_idx_d   = init_idx_q;
        wr_start     = 1'b0;
        wr_rs        = 1'b0;
        wr_byte      = 8'h00;
        wr_long      = 1'b0;
        case (state_q)
            ST_POWER_WAIT: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = ST_INIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + ONE;
                end
            end
            ST_INIT: begin
                if (!wr_busy) begin
                    if (init_idx_q == 3'd4) begin
                        // clear has fully settled
                        ready_d = 1'b1;
                        raddr_d = 5'd0;
                        state_d = ST_SET_ROW;
                    end else begin
                        wr_start   = 1'b1;
                        wr_byte    = init_cmd(init_idx_q[1:0]);
                        wr_long    = (init_idx_q == 3'd3);
                        init_idx_d = init_idx_q + 3'd1;
                    end
                end
            end
            ST_SET_ROW: begin
                if (!wr_busy) begin
                    wr_start = 1'b1;
                    wr_byte  = raddr_q[4] ? ROW1_ADDR : ROW0_ADDR;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // raddr has been stable since the previous character, so rdata
                // is valid once the previous byte finishes; the following clock
                // is the fetch clock in which it gets captured.
                if (!wr_busy) begin
                    state_d = ST_WRITE_CHAR;
                end
            end
            ST_WRITE_CHAR: begin
                if (!wr_busy) begin
                    wr_start = 1'b1;
                    wr_rs    = 1'b1;
                    wr_byte  = rdata_i;
                    raddr_d  = raddr_q + 5'd1;
                    if (raddr_q == 5'd31) begin
                        state_d = ST_FRAME_END;
                    end else if (raddr_q[3:0] == 4'hF) begin
                        state_d = ST_SET_ROW;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FRAME_END: begin
                // pulse once the last character has settled
                if (!wr_busy) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_SET_ROW;
                end
            end
            default: state_d = ST_POWER_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_POWER_WAIT;
            raddr_q      <= 5'd0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            pwr_cnt_q    <= '0;
            init_idx_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            raddr_q      <= raddr_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            pwr_cnt_q    <= pwr_cnt_d;
            init_idx_q   <= init_idx_d;
        end
    end

    assign raddr_o      = raddr_q;
    assign lcd_rw_o     = 1'b0;
    assign ready_o      = ready_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_lcd_refresher.sv
// Purpose : directed check of lcd_refresher init sequence, frame content, strobe
//           timing, frame_done spacing and asynchronous reset.
// Latency : n/a (testbench).
// Backpressure: n/a; RAM model answers with one clock of read latency.
module tb_lcd_refresher;

    localparam int PW        = 10;
    localparam int EC        = 2;
    localparam int CC        = 4;
    localparam int CL        = 8;
    localparam int BYTE_LEN  = 1 + EC + CC;
    localparam int FRAME_LEN = 34 * BYTE_LEN + 32 + 1;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         c;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] raddr;
    logic [7:0] rdata = 8'h00;
    logic       lcd_rs, lcd_rw, lcd_e, ready, frame_done;
    logic [7:0] lcd_data;

    logic [7:0] mem [32];
    ent_t       log_q[$];
    int         fd_q[$];
    int         rdy_cyc;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         rel;

    logic       e_p = 1'b0, rs_p = 1'b0, fd_p = 1'b0, rdy_p = 1'b0;
    logic [7:0] d_p = 8'h00;
    int         e_w = 0;

    lcd_refresher #(
        .POWER_CYC (PW),
        .E_CYC     (EC),
        .CMD_CYC   (CC),
        .CLEAR_CYC (CL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .raddr_o      (raddr),
        .rdata_i      (rdata),
        .lcd_rs_o     (lcd_rs),
        .lcd_rw_o     (lcd_rw),
        .lcd_e_o      (lcd_e),
        .lcd_data_o   (lcd_data),
        .ready_o      (ready),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            e_p   <= 1'b0;
            fd_p  <= 1'b0;
            rdy_p <= 1'b0;
            e_w   <= 0;
        end else begin
            if (lcd_e) begin
                chk("e_hold_rs", 32'(lcd_rs), 32'(rs_p));
                chk("e_hold_dat", 32'(lcd_data), 32'(d_p));
                if (!e_p) begin
                    log_q.push_back('{lcd_rs, lcd_data, cyc});
                    chk("rw_zero", 32'(lcd_rw), 0);
                    e_w <= 1;
                end else begin
                    e_w <= e_w + 1;
                end
            end else if (e_p) begin
                chk("e_width", e_w, EC);
            end
            if (frame_done) begin
                fd_q.push_back(cyc);
                chk("fd_raddr_wrap", 32'(raddr), 0);
                chk("fd_one_clk", 32'(fd_p), 0);
            end
            if (ready && !rdy_p) rdy_cyc <= cyc;
            if (rdy_p) chk("ready_sticky", 32'(ready), 1);
            e_p   <= lcd_e;
            rs_p  <= lcd_rs;
            d_p   <= lcd_data;
            fd_p  <= frame_done;
            rdy_p <= ready;
        end
    end

    task automatic wait_bytes(input int n);
        int b = 0;
        while (log_q.size() < n && b < 3000) begin
            @(negedge clk);
            b++;
        end
        chk("wait_bytes", 32'(log_q.size() >= n), 1);
    endtask

    task automatic wait_fd(input int n);
        int b = 0;
        while (fd_q.size() < n && b < 3000) begin
            @(negedge clk);
            b++;
        end
        chk("wait_frame_done", 32'(fd_q.size() >= n), 1);
    endtask

    task automatic check_init(input int rel_c);
        logic [7:0] cmds [4];
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        wait_bytes(5);
        // 10 silent power-wait clocks plus the setup clock, at most one sequencing clock more
        chk("pwr_wait_min", 32'((log_q[0].c - rel_c) >= PW + 1), 1);
        chk("pwr_wait_max", 32'((log_q[0].c - rel_c) <= PW + 2), 1);
        for (int i = 0; i < 4; i++)
            chk("init_cmd", {23'd0, log_q[i].rs, log_q[i].d}, {24'd0, cmds[i]});
        for (int i = 0; i < 3; i++)
            chk("init_spacing", log_q[i+1].c - log_q[i].c, BYTE_LEN);
        chk("ready_after_clear", rdy_cyc - log_q[3].c, EC + CL);
        chk("first_row_cmd", {23'd0, log_q[4].rs, log_q[4].d}, 32'h080);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]      = 8'(8'h41 + i);
            mem[16 + i] = 8'(8'h61 + i);
        end
        rdy_cyc = -1;
        repeat (3) @(negedge clk);
        chk("rst_raddr", 32'(raddr), 0);
        chk("rst_lcd_e", 32'(lcd_e), 0);
        chk("rst_lcd_rs", 32'(lcd_rs), 0);
        chk("rst_lcd_rw", 32'(lcd_rw), 0);
        chk("rst_lcd_data", 32'(lcd_data), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        rel = cyc;
        rst_n = 1'b1;
        check_init(rel);

        // Frame 1 (second frame): once cell 6 has been sent, cell 5 is history.
        wait_bytes(4 + 34 + 8);
        mem[5] = 8'h5A;

        wait_fd(3);
        wait_bytes(4 + 34 * 3 + 1);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 34; k++) begin
                logic [8:0] e;
                if (k == 0)                  e = 9'h080;
                else if (k <= 16)            e = {1'b1, 8'(8'h40 + k)};
                else if (k == 17)            e = 9'h0C0;
                else                         e = {1'b1, 8'(8'h61 + k - 18)};
                if (f == 2 && k == 6)        e = 9'h15A;
                chk("frame_byte", {23'd0, log_q[4 + 34*f + k].rs, log_q[4 + 34*f + k].d},
                    {23'd0, e});
            end
            chk("fd_after_last_char", 32'(fd_q[f] > log_q[4 + 34*f + 33].c + EC), 1);
            chk("fd_before_next_row", 32'(fd_q[f] < log_q[4 + 34*(f+1)].c), 1);
        end
        chk("fd_count", fd_q.size(), 3);
        chk("fd_spacing_01", fd_q[1] - fd_q[0], FRAME_LEN);
        chk("fd_spacing_12", fd_q[2] - fd_q[1], FRAME_LEN);

        // Reset in the middle of an E pulse.
        begin
            int b = 0;
            while (lcd_e !== 1'b1 && b < 100) begin
                @(negedge clk);
                b++;
            end
            chk("see_e_high", 32'(lcd_e), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lcd_e", 32'(lcd_e), 0);
        chk("arst_ready", 32'(ready), 0);
        chk("arst_raddr", 32'(raddr), 0);
        chk("arst_lcd_data", 32'(lcd_data), 0);
        repeat (3) @(negedge clk);
        log_q.delete();
        fd_q.delete();
        rdy_cyc = -1;
        rel = cyc;
        rst_n = 1'b1;
        check_init(rel);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
